axil_master: RTL

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axil_master.sv
// AXI4-Lite single-outstanding master: one user command in, one AXI
// transaction out, one completion back, with a handshake-wait timeout.
module axil_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                aclk,
  input  logic                areset,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [2:0]          rsp_status
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_RSP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_tmo;
  logic [TW-1:0]       r_tmo;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic                r_bready;
  logic                r_rready;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [2:0]          r_rsp_status;

  logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_any_hs, w_tmo_hit, w_wait;

  assign w_cmd_hs  = cmd_valid && r_cmd_ready;
  assign w_aw_hs   = r_awvalid && m_axi_awready;
  assign w_w_hs    = r_wvalid && m_axi_wready;
  assign w_b_hs    = r_bready && m_axi_bvalid;
  assign w_ar_hs   = r_arvalid && m_axi_arready;
  assign w_r_hs    = r_rready && m_axi_rvalid;
  assign w_any_hs  = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
  // Fires on the cycle whose increment would make the count reach TIMEOUT.
  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo == TW'(TIMEOUT - 1));
  assign w_wait    = (r_state == S_WR) || (r_state == S_WRESP) ||
                     (r_state == S_RADDR) || (r_state == S_RDATA);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_cmd_hs) w_state_nxt = cmd_write ? S_WR : S_RADDR;
      S_WR:
        if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs))
          w_state_nxt = S_WRESP;
        else if (!w_aw_hs && !w_w_hs && w_tmo_hit)
          w_tmo = 1'b1;
      S_WRESP:
        if (w_b_hs) w_state_nxt = S_RSP;
        else if (w_tmo_hit) w_tmo = 1'b1;
      S_RADDR:
        if (w_ar_hs) w_state_nxt = S_RDATA;
        else if (w_tmo_hit) w_tmo = 1'b1;
      S_RDATA:
        if (w_r_hs) w_state_nxt = S_RSP;
        else if (w_tmo_hit) w_tmo = 1'b1;
      S_RSP:
        if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_tmo) w_state_nxt = S_RSP;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tmo        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_bready    <= (w_state_nxt == S_WRESP);
      r_rready    <= (w_state_nxt == S_RDATA);
      r_rsp_valid <= (w_state_nxt == S_RSP);
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
        r_arvalid <= !cmd_write;
      end else begin
        r_awvalid <= r_awvalid && !w_aw_hs && !w_tmo;
        r_wvalid  <= r_wvalid && !w_w_hs && !w_tmo;
        r_arvalid <= r_arvalid && !w_ar_hs && !w_tmo;
      end
      if (w_state_nxt != r_state || w_any_hs) r_tmo <= '0;
      else if (w_wait) r_tmo <= r_tmo + TW'(1);
      if (w_tmo) begin
        r_rsp_rdata  <= '0;
        r_rsp_status <= 3'b111;
      end else if (w_b_hs) begin
        r_rsp_rdata  <= '0;
        r_rsp_status <= {1'b0, m_axi_bresp};
      end else if (w_r_hs) begin
        r_rsp_rdata  <= m_axi_rdata;
        r_rsp_status <= {1'b0, m_axi_rresp};
      end
    end
  end

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_status    = r_rsp_status;

endmodule
